fifo_rd_packer: RTL and testbench
=================================

FIFO_RD_PACKER -- requirements
Module: fifo_rd_packer

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 8, meaning the width of one input beat, matching the async FIFO read-data width.
REQ-002 SHALL provide parameter PACK_RATIO, default 4, meaning the number of input beats per output word; legal values are 2 to 16.
REQ-003 SHALL provide port rclk, input, 1 bit: the single clock, the async FIFO read-side clock.
REQ-004 SHALL provide port rrst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL provide in_valid, input, 1 bit: beat available, driven by the FIFO r_valid.
REQ-006 SHALL provide in_ready, output, 1 bit: beat accepted this cycle, driving the FIFO r_ready.
REQ-007 SHALL provide in_data, input, DATA_WIDTH bits: beat data, driven by the FIFO r_data.
REQ-008 SHALL provide out_valid, output, 1 bit: packed word available.
REQ-009 SHALL provide out_ready, input, 1 bit: downstream accepts the word.
REQ-010 SHALL provide out_data, output, DATA_WIDTH*PACK_RATIO bits: packed word.
REQ-011 SHALL provide out_keep, output, PACK_RATIO bits: bit i set means lane i holds valid data.

Function
REQ-012 SHALL transfer an input beat only on a cycle where in_valid and in_ready are both 1.
REQ-013 SHALL transfer an output word only on a cycle where out_valid and out_ready are both 1.
REQ-014 SHALL place the k-th accepted beat of a word (k from 0) in lane k, at out_data bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-015 SHALL hold a lane counter of width clog2(PACK_RATIO) that wraps from PACK_RATIO-1 to 0 on completion of a word.
REQ-016 SHALL contain a two-deep buffer: an accumulator plus an output register.
REQ-017 SHALL implement states FILL and WAIT.
- FILL: in_ready=1.
- WAIT: the accumulator holds a complete word; in_ready=0.
REQ-018 SHALL complete a word when the last lane is accepted. If the output register is empty or draining that cycle, the word moves to the output register at the same edge; otherwise the state goes FILL->WAIT.
REQ-019 SHALL, in WAIT, move the accumulator into the output register on the cycle the output drains, then return to FILL. in_ready stays 0 during that cycle.
REQ-020 SHALL assert out_valid exactly one rclk cycle after the completing beat is accepted, when the output register was free.
REQ-021 SHALL hold out_valid, out_data and out_keep stable while out_valid=1 and out_ready=0.
REQ-022 SHALL drive zero in unused lanes of a partial word.
REQ-023 SHALL emit words in acceptance order, and SHALL never drop or duplicate a beat.

Reset
REQ-024 SHALL, while rrst_n=0, force: out_valid=0, out_data=0, out_keep=0, lane counter=0, state=FILL, in_ready=0.
REQ-025 SHALL, on rrst_n asserted mid-operation, discard any partial or held word.
REQ-026 SHALL allow in_ready=1 on the first rclk edge after rrst_n deasserts.

Configuration
REQ-027 SHALL, when macro FIFO_RD_PACKER_FLUSH_EN is defined, add input port flush, 1 bit.
REQ-028 SHALL, with flush=1 in FILL and counter>0, emit the partial word with out_keep set for the filled lanes. The emitted word follows the same output-register rules as REQ-018.
REQ-029 SHALL, when flush coincides with an accepted beat, include that beat in the flushed word.
REQ-030 SHALL ignore flush in WAIT, and in FILL when counter=0 and no beat is accepted.
REQ-031 SHALL, without FIFO_RD_PACKER_FLUSH_EN, have no flush port, emit full words only, and hold out_keep at all ones whenever out_valid=1.

Verification (DATA_WIDTH=8, PACK_RATIO=4)
REQ-032 SHALL cover: beats 0x11,0x22,0x33,0x44 back-to-back with out_ready=1 -> out_data=0x44332211, out_keep=0xF, out_valid on the cycle after 0x44.
REQ-033 SHALL cover: out_ready=0 while 8 beats are offered -> in_ready falls after the 8th beat; setting out_ready=1 then yields two words in order, and in_ready returns to 1.
REQ-034 SHALL cover: reset pulse after 2 beats, then beats 0xA1..0xA4 -> single word 0xA4A3A2A1; no partial word is ever emitted.
REQ-035 SHALL cover (flush enabled): beats 0xAA,0xBB, then flush -> out_data=0x0000BBAA, out_keep=0x3.
REQ-036 SHALL cover (flush enabled): flush coincident with the third beat 0xCC after 0x01,0x02 -> out_data=0x00CC0201, out_keep=0x7.
REQ-037 SHALL cover (flush enabled): flush at counter=0 with in_valid=0 -> out_valid stays 0.

Source files
------------

// File: rtl/fifo_rd_packer.sv
// Packs DATA_WIDTH beats from an async FIFO read port into PACK_RATIO-lane words.
// Define FIFO_RD_PACKER_FLUSH_EN to add a flush input that emits partial words.
module fifo_rd_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int PACK_RATIO = 4
) (
  input  logic                             rclk,
  input  logic                             rrst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [DATA_WIDTH-1:0]            in_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DATA_WIDTH*PACK_RATIO-1:0] out_data,
  output logic [PACK_RATIO-1:0]            out_keep
`ifdef FIFO_RD_PACKER_FLUSH_EN
  ,
  input  logic                             flush
`endif
);

  localparam int CW = $clog2(PACK_RATIO);
  localparam int WW = DATA_WIDTH * PACK_RATIO;
  localparam logic [CW-1:0] LAST_LANE = CW'(PACK_RATIO - 1);

  typedef enum logic {
    ST_FILL,
    ST_WAIT
  } state_t;

  state_t                r_state;
  state_t                w_stateNext;
  logic [WW-1:0]         r_acc;
  logic [PACK_RATIO-1:0] r_accKeep;
  logic [CW-1:0]         r_cnt;
  logic [WW-1:0]         r_outData;
  logic [PACK_RATIO-1:0] r_outKeep;
  logic                  r_outValid;

  logic                  w_inFire;
  logic                  w_outFire;
  logic                  w_outFree;
  logic                  w_flushHit;
  logic                  w_complete;
  logic [WW-1:0]         w_accNext;
  logic [PACK_RATIO-1:0] w_keep;

  assign in_ready  = rrst_n && (r_state == ST_FILL);
  assign out_valid = r_outValid;
  assign out_data  = r_outData;
  assign out_keep  = r_outKeep;

  assign w_inFire  = in_valid && in_ready;
  assign w_outFire = r_outValid && out_ready;
  assign w_outFree = !r_outValid || out_ready;

`ifdef FIFO_RD_PACKER_FLUSH_EN
  assign w_flushHit = flush && (r_state == ST_FILL) && ((r_cnt != '0) || w_inFire);
`else
  assign w_flushHit = 1'b0;
`endif

  assign w_complete = (w_inFire && (r_cnt == LAST_LANE)) || w_flushHit;

  // Accumulator contents and lane mask as they would look after this cycle's beat.
  always_comb begin
    w_accNext = r_acc;
    w_keep    = '0;
    for (int i = 0; i < PACK_RATIO; i++) begin
      if (CW'(i) < r_cnt) w_keep[i] = 1'b1;
      if (w_inFire && (CW'(i) == r_cnt)) begin
        w_keep[i] = 1'b1;
        w_accNext[i*DATA_WIDTH +: DATA_WIDTH] = in_data;
      end
    end
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      ST_FILL: if (w_complete && !w_outFree) w_stateNext = ST_WAIT;
      ST_WAIT: if (w_outFire) w_stateNext = ST_FILL;
    endcase
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) r_state <= ST_FILL;
    else         r_state <= w_stateNext;
  end

  // A finished word bypasses the accumulator when the output register is free;
  // otherwise it parks in the accumulator until the output drains.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_acc      <= '0;
      r_accKeep  <= '0;
      r_cnt      <= '0;
      r_outData  <= '0;
      r_outKeep  <= '0;
      r_outValid <= 1'b0;
    end else if (r_state == ST_FILL) begin
      if (w_complete) begin
        r_cnt <= '0;
        if (w_outFree) begin
          r_outData  <= w_accNext;
          r_outKeep  <= w_keep;
          r_outValid <= 1'b1;
          r_acc      <= '0;
        end else begin
          r_acc     <= w_accNext;
          r_accKeep <= w_keep;
        end
      end else begin
        if (w_inFire) begin
          r_acc <= w_accNext;
          r_cnt <= r_cnt + 1'b1;
        end
        if (w_outFire) r_outValid <= 1'b0;
      end
    end else if (w_outFire) begin
      r_outData <= r_acc;
      r_outKeep <= r_accKeep;
      r_acc     <= '0;
    end
  end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed self-checking bench for fifo_rd_packer (DATA_WIDTH=8, PACK_RATIO=4).
// Flush scenarios run only when FIFO_RD_PACKER_FLUSH_EN is defined.
module tb_fifo_rd_packer;

  logic        rclk;
  logic        rrst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_keep;
`ifdef FIFO_RD_PACKER_FLUSH_EN
  logic        flush;
`endif

  int vectors;
  int miscompares;

  fifo_rd_packer #(
    .DATA_WIDTH(8),
    .PACK_RATIO(4)
  ) dut (
    .rclk      (rclk),
    .rrst_n    (rrst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_keep  (out_keep)
`ifdef FIFO_RD_PACKER_FLUSH_EN
    ,
    .flush     (flush)
`endif
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  // Inputs change on the falling edge; outputs are sampled there too.
  task automatic test_reset();
    rrst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
`ifdef FIFO_RD_PACKER_FLUSH_EN
    flush = 1'b0;
`endif
    repeat (2) @(negedge rclk);
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_out_valid got %b want 0", out_valid); end
    vectors++;
    if (out_data !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_out_data got %h want 00000000", out_data); end
    vectors++;
    if (out_keep !== 4'h0) begin miscompares++; $display("[TB] FAIL reset_out_keep got %h want 0", out_keep); end
    vectors++;
    if (in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_in_ready got %b want 0", in_ready); end
    rrst_n = 1'b1;
    @(negedge rclk);
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL post_reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_basic();
    logic [7:0] beats [4];
    beats = '{8'h11, 8'h22, 8'h33, 8'h44};
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k != 0) @(negedge rclk);
      vectors++;
      if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL basic_early_valid beat %0d got %b want 0", k, out_valid); end
      vectors++;
      if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL basic_in_ready beat %0d got %b want 1", k, in_ready); end
      in_valid = 1'b1;
      in_data  = beats[k];
    end
    @(negedge rclk);
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL basic_out_valid got %b want 1", out_valid); end
    vectors++;
    if (out_data !== 32'h44332211) begin miscompares++; $display("[TB] FAIL basic_out_data got %h want 44332211", out_data); end
    vectors++;
    if (out_keep !== 4'hF) begin miscompares++; $display("[TB] FAIL basic_out_keep got %h want f", out_keep); end
    @(negedge rclk);
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL basic_drained got %b want 0", out_valid); end
  endtask

  task automatic test_back_pressure();
    out_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge rclk);
      vectors++;
      if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL bp_in_ready beat %0d got %b want 1", k, in_ready); end
      in_valid = 1'b1;
      in_data  = 8'(k + 1);
    end
    @(negedge rclk);
    in_data = 8'h09;
    vectors++;
    if (in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_stalled got %b want 0", in_ready); end
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 32'h04030201) begin
      miscompares++; $display("[TB] FAIL bp_word0 got valid=%b data=%h want valid=1 data=04030201", out_valid, out_data);
    end
    @(negedge rclk);
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 32'h04030201 || out_keep !== 4'hF) begin
      miscompares++; $display("[TB] FAIL bp_hold got valid=%b data=%h keep=%h want 1/04030201/f", out_valid, out_data, out_keep);
    end
    vectors++;
    if (in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_still_stalled got %b want 0", in_ready); end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_drain_cycle_in_ready got %b want 0", in_ready); end
    @(negedge rclk);
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 32'h08070605) begin
      miscompares++; $display("[TB] FAIL bp_word1 got valid=%b data=%h want valid=1 data=08070605", out_valid, out_data);
    end
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL bp_resume got %b want 1", in_ready); end
    @(negedge rclk);
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_empty got %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h55;
    @(negedge rclk);
    in_data = 8'h66;
    @(negedge rclk);
    in_valid = 1'b0;
    rrst_n   = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      miscompares++; $display("[TB] FAIL midreset_forced got in_ready=%b out_valid=%b want 0/0", in_ready, out_valid);
    end
    @(negedge rclk);
    rrst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge rclk);
      vectors++;
      if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL midreset_partial beat %0d got valid=%b data=%h want 0", k, out_valid, out_data); end
      in_valid = 1'b1;
      in_data  = 8'(8'hA1 + k);
    end
    @(negedge rclk);
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 32'hA4A3A2A1) begin
      miscompares++; $display("[TB] FAIL midreset_word got valid=%b data=%h want valid=1 data=a4a3a2a1", out_valid, out_data);
    end
    @(negedge rclk);
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL midreset_extra_word got %b want 0", out_valid); end
  endtask

`ifdef FIFO_RD_PACKER_FLUSH_EN
  task automatic test_flush_partial();
    out_ready = 1'b1;
    @(negedge rclk);
    in_valid = 1'b1; in_data = 8'hAA;
    @(negedge rclk);
    in_data = 8'hBB;
    @(negedge rclk);
    in_valid = 1'b0; flush = 1'b1;
    @(negedge rclk);
    flush = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 32'h0000BBAA || out_keep !== 4'h3) begin
      miscompares++; $display("[TB] FAIL flush_partial got %b/%h/%h want 1/0000bbaa/3", out_valid, out_data, out_keep);
    end
    @(negedge rclk);
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_partial_drain got %b want 0", out_valid); end
  endtask

  task automatic test_flush_coincident();
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 8'h01;
    @(negedge rclk);
    in_data = 8'h02;
    @(negedge rclk);
    in_data = 8'hCC; flush = 1'b1;
    @(negedge rclk);
    in_valid = 1'b0; flush = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 32'h00CC0201 || out_keep !== 4'h7) begin
      miscompares++; $display("[TB] FAIL flush_coincident got %b/%h/%h want 1/00cc0201/7", out_valid, out_data, out_keep);
    end
    @(negedge rclk);
  endtask

  task automatic test_flush_idle();
    out_ready = 1'b1;
    in_valid = 1'b0; flush = 1'b1;
    @(negedge rclk);
    flush = 1'b0;
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_idle got %b want 0", out_valid); end
    @(negedge rclk);
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_idle_later got %b want 0", out_valid); end
  endtask
`endif

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_basic();
    test_back_pressure();
    test_reset_mid();
`ifdef FIFO_RD_PACKER_FLUSH_EN
    test_flush_partial();
    test_flush_coincident();
    test_flush_idle();
`endif
    @(negedge rclk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
